grid_mask_gen: RTL and testbench

// - Upstream neighbour of the grid colour stage. Tracks upscaled output video timing.
// - Marks which output pixels lie on the boundary between scaled GBA pixels
//   (the pixel-grid lines). Produces gridAct plus pixel/sync outputs delayed to align with it.
// - Its outputs feed the grid colour stage directly: gridAct and pxlOut* connect straight across.

---
 rtl/gbahd_video_pkg.sv | 19 +
 rtl/scale_phase_cnt.sv | 47 ++++
 rtl/grid_mask_gen.sv | 129 ++++++++++++
 tb/tb_grid_mask_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/gbahd_video_pkg.sv
// Shared types and dimensions for the upscaled GBA video path.
package gbahd_video_pkg;

   localparam int unsigned GBA_W = 240;
   localparam int unsigned GBA_H = 160;
   localparam int unsigned CNT_W = 11;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      ACTIVE    = 1'b1
   } grid_state_t;

endpackage

// File: rtl/scale_phase_cnt.sv
// Window-gated modulo-SCALE phase counter for one axis.
// phase/inWin describe the current position; registers hold the state of the next one.
module scale_phase_cnt #(
   parameter int unsigned SCALE = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       step,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] phase,
   output logic       inWin
);

   localparam logic [3:0] PH_LAST = 4'(SCALE - 1);

   logic [3:0] ph_q;
   logic [3:0] ph_d;
   logic       win_q;

   // clr means the position restarts at 0, so registered state is stale this cycle
   always_comb begin
      inWin = clr ? 1'b0 : win_q;
      if (start) begin
         inWin = 1'b1;
      end else if (stop) begin
         inWin = 1'b0;
      end
      phase = (inWin && !start && !clr) ? ph_q : 4'd0;
      ph_d  = phase;
      if (step && inWin) begin
         ph_d = (phase == PH_LAST) ? 4'd0 : phase + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q  <= 4'd0;
         win_q <= 1'b0;
      end else begin
         ph_q  <= ph_d;
         win_q <= inWin;
      end
   end

endmodule

// File: rtl/grid_mask_gen.sv
// Tracks upscaled output timing and flags pixels on GBA pixel-grid lines,
// delaying pixel and sync signals by one clock to stay aligned with gridAct.
module grid_mask_gen
   import gbahd_video_pkg::*;
#(
   parameter int unsigned SCALE  = 6,
   parameter int unsigned X_OFF  = 240,
   parameter int unsigned Y_OFF  = 60,
   parameter int unsigned GRID_W = 1,
   parameter bit          VS_POL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pxlInRed,
   input  logic [7:0] pxlInGreen,
   input  logic [7:0] pxlInBlue,
   input  logic       deIn,
   input  logic       hsIn,
   input  logic       vsIn,
   input  logic       gridEnIn,
   output logic [7:0] pxlOutRed,
   output logic [7:0] pxlOutGreen,
   output logic [7:0] pxlOutBlue,
   output logic       deOut,
   output logic       hsOut,
   output logic       vsOut,
   output logic       gridAct
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] X_END   = CNT_W'(X_OFF + GBA_W * SCALE);
   localparam logic [CNT_W-1:0] Y_END   = CNT_W'(Y_OFF + GBA_H * SCALE);
   localparam logic [3:0]       THR     = 4'(SCALE - GRID_W);

   grid_state_t      state_q, state_d;
   logic [CNT_W-1:0] x_q, y_q, x_cur, y_cur, x_d, y_d;
   logic             vs_prev, grid_en_q;
   logic             fs_c, fall_c, en_c, grid_c;
   logic [3:0]       sub_x, sub_y;
   logic             in_x, in_y;
   rgb_t             pxl_q;

   assign fs_c   = (vsIn == VS_POL) && (vs_prev != VS_POL);
   assign fall_c = deOut && !deIn;

   // Next-state, counter update and grid decision; frame start overrides the stored counts
   always_comb begin
      state_d = state_q;
      x_cur   = (fs_c || fall_c) ? '0 : x_q;
      y_cur   = fs_c ? '0 : y_q;
      x_d     = x_cur;
      y_d     = y_cur;
      if (deIn && x_cur != CNT_MAX) begin
         x_d = x_cur + CNT_W'(1);
      end
      if (fall_c && !fs_c && y_cur != CNT_MAX) begin
         y_d = y_cur + CNT_W'(1);
      end
      en_c   = fs_c ? gridEnIn : grid_en_q;
      grid_c = ((state_q == ACTIVE) || fs_c) && en_c && deIn && in_x && in_y &&
               ((sub_x >= THR) || (sub_y >= THR));
      case (state_q)
         WAIT_SYNC: if (fs_c) state_d = ACTIVE;
         ACTIVE:    state_d = ACTIVE;
         default:   state_d = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         vs_prev   <= VS_POL;
         grid_en_q <= 1'b0;
         pxl_q     <= '0;
         deOut     <= 1'b0;
         hsOut     <= 1'b0;
         vsOut     <= 1'b0;
         gridAct   <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         vs_prev <= vsIn;
         if (fs_c) begin
            grid_en_q <= gridEnIn;
         end
         pxl_q   <= {pxlInRed, pxlInGreen, pxlInBlue};
         deOut   <= deIn;
         hsOut   <= hsIn;
         vsOut   <= vsIn;
         gridAct <= grid_c;
      end
   end

   assign pxlOutRed   = pxl_q.red;
   assign pxlOutGreen = pxl_q.green;
   assign pxlOutBlue  = pxl_q.blue;

   scale_phase_cnt #(.SCALE(SCALE)) u_phase_x (
      .clk   (clk),
      .rst   (rst),
      .clr   (fs_c || fall_c),
      .step  (deIn),
      .start (x_cur == CNT_W'(X_OFF)),
      .stop  (x_cur == X_END),
      .phase (sub_x),
      .inWin (in_x)
   );

   scale_phase_cnt #(.SCALE(SCALE)) u_phase_y (
      .clk   (clk),
      .rst   (rst),
      .clr   (fs_c),
      .step  (fall_c && !fs_c),
      .start (y_cur == CNT_W'(Y_OFF)),
      .stop  (y_cur == Y_END),
      .phase (sub_y),
      .inWin (in_y)
   );

endmodule

// File: tb/tb_grid_mask_gen.sv
// Directed bench for grid_mask_gen: default instance plus a GRID_W=2 instance on shared stimulus.
module tb_grid_mask_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] red = 8'h0, green = 8'h0, blue = 8'h0;
   logic       de = 1'b0, hs = 1'b0, vs = 1'b0, gen = 1'b0;

   logic [7:0] r1, g1, b1, r2, g2, b2;
   logic       de1, hs1, vs1, ga1, de2, hs2, vs2, ga2;

   int         n_chk = 0;
   int         n_pass = 0;
   int         ln = 0;
   logic       gx1 [0:2047];
   logic       gx2 [0:2047];
   logic [23:0] last_rgb;
   logic        last_hs;

   always #5 clk = ~clk;

   grid_mask_gen dut (
      .clk(clk), .rst(rst), .pxlInRed(red), .pxlInGreen(green), .pxlInBlue(blue),
      .deIn(de), .hsIn(hs), .vsIn(vs), .gridEnIn(gen),
      .pxlOutRed(r1), .pxlOutGreen(g1), .pxlOutBlue(b1),
      .deOut(de1), .hsOut(hs1), .vsOut(vs1), .gridAct(ga1)
   );

   grid_mask_gen #(.GRID_W(2)) dut_w2 (
      .clk(clk), .rst(rst), .pxlInRed(red), .pxlInGreen(green), .pxlInBlue(blue),
      .deIn(de), .hsIn(hs), .vsIn(vs), .gridEnIn(gen),
      .pxlOutRed(r2), .pxlOutGreen(g2), .pxlOutBlue(b2),
      .deOut(de2), .hsOut(hs2), .vsOut(vs2), .gridAct(ga2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Drive one cycle, then sample the registered outputs for that cycle's inputs
   task automatic step(input logic d, input logic v);
      de = d;
      vs = v;
      hs = 1'($urandom_range(0, 1));
      {red, green, blue} = d ? 24'($urandom) : 24'h0;
      last_rgb = {red, green, blue};
      last_hs  = hs;
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0);
         gx1[i] = ga1;
         gx2[i] = ga2;
      end
      step(1'b0, 1'b0);
      ln++;
   endtask

   task automatic lines_to(input int target);
      while (ln < target) line(2);
   endtask

   task automatic vsync();
      step(1'b0, 1'b1);
      check("vs_pass", {31'd0, vs1}, 32'd1);
      step(1'b0, 1'b0);
      ln = 0;
   endtask

   initial begin
      gen = 1'b1;
      rst = 1'b1;
      step(1'b1, 1'b0);
      check("reset_outs", {r1, g1, b1, de1, hs1, vs1, ga1}, 32'd0);
      rst = 1'b0;

      // no vsync yet: pass-through only
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         check("pass_rgb", {8'd0, r1, g1, b1}, {8'd0, last_rgb});
         check("pass_de_hs", {30'd0, de1, hs1}, {30'd0, 1'b1, last_hs});
         check("pass_w2", {8'd0, r2, g2, b2}, {8'd0, last_rgb});
         check("nosync_ga", {31'd0, ga1}, 32'd0);
      end
      step(1'b0, 1'b0);
      check("pass_de_lo", {31'd0, de1}, 32'd0);
      ln = 1;
      lines_to(60);
      line(246);
      check("nosync_l60_x245", {31'd0, gx1[245]}, 32'd0);

      // grid enabled frame
      vsync();
      lines_to(59);
      line(246);
      check("l59_x245", {31'd0, gx1[245]}, 32'd0);
      line(247);
      check("l60_x245", {31'd0, gx1[245]}, 32'd1);
      check("l60_x244", {31'd0, gx1[244]}, 32'd0);
      check("l60_x246", {31'd0, gx1[246]}, 32'd0);
      check("l60_x240", {31'd0, gx1[240]}, 32'd0);
      check("w2_l60_x245", {31'd0, gx2[245]}, 32'd1);
      check("w2_l60_x244", {31'd0, gx2[244]}, 32'd1);
      check("w2_l60_x243", {31'd0, gx2[243]}, 32'd0);
      line(245);
      check("l61_x244", {31'd0, gx1[244]}, 32'd0);
      lines_to(64);
      line(246);
      check("l64_x240", {31'd0, gx1[240]}, 32'd0);
      check("w2_l64_x240", {31'd0, gx2[240]}, 32'd1);
      line(1681);
      check("l65_x244", {31'd0, gx1[244]}, 32'd1);
      check("l65_x239", {31'd0, gx1[239]}, 32'd0);
      check("l65_x1679", {31'd0, gx1[1679]}, 32'd1);
      check("l65_x1680", {31'd0, gx1[1680]}, 32'd0);
      check("l65_x0", {31'd0, gx1[0]}, 32'd0);
      lines_to(1019);
      line(246);
      check("l1019_x245", {31'd0, gx1[245]}, 32'd1);
      check("l1019_x244", {31'd0, gx1[244]}, 32'd1);
      line(246);
      check("l1020_x244", {31'd0, gx1[244]}, 32'd0);
      check("l1020_x245", {31'd0, gx1[245]}, 32'd0);

      // grid disabled at frame start, enabled mid-frame
      gen = 1'b0;
      vsync();
      lines_to(60);
      line(246);
      check("en0_l60_x245", {31'd0, gx1[245]}, 32'd0);
      lines_to(300);
      gen = 1'b1;
      lines_to(305);
      line(246);
      check("midfrm_l305_x245", {31'd0, gx1[245]}, 32'd0);
      check("midfrm_l305_x244", {31'd0, gx1[244]}, 32'd0);
      vsync();
      lines_to(60);
      line(246);
      check("en_next_l60_x245", {31'd0, gx1[245]}, 32'd1);

      // reset mid-frame
      lines_to(100);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      rst = 1'b1;
      step(1'b1, 1'b0);
      check("midrst_outs", {r1, g1, b1, de1, hs1, vs1, ga1}, 32'd0);
      check("midrst_w2", {r2, g2, b2, de2, hs2, vs2, ga2}, 32'd0);
      rst = 1'b0;
      ln = 0;
      lines_to(60);
      line(246);
      check("rst_nosync_x245", {31'd0, gx1[245]}, 32'd0);
      vsync();
      lines_to(60);
      line(246);
      check("rst_sync_x245", {31'd0, gx1[245]}, 32'd1);
      check("rst_sync_x244", {31'd0, gx1[244]}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
